// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse sequencer: default field width and FSM state encoding.
package pulse_seq_pkg;

  localparam int CW_DEF = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_DELAY = 3'd1;
  localparam state_t S_HIGH  = 3'd2;
  localparam state_t S_LOW   = 3'd3;
  localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/pulse_sequencer_if.sv
// Control/configuration and status bundle of the pulse sequencer.
interface pulse_sequencer_if import pulse_seq_pkg::*; #(
  parameter int CW = CW_DEF
) ();

  logic          on;
  logic          start;
  logic [CW-1:0] delay;
  logic [CW-1:0] width;
  logic [CW-1:0] gap;
  logic [CW-1:0] count;
  logic          signal;
  logic          busy;
  logic          done;
  logic          abort;

  modport master (
    output on, start, delay, width, gap, count,
    input  signal, busy, done, abort
  );

  modport slave (
    input  on, start, delay, width, gap, count,
    output signal, busy, done, abort
  );

endinterface

// File: rtl/pulse_sequencer_cycle_counter.sv
// Loadable down-counter that saturates at zero; times the DELAY, HIGH and LOW phases.
module cycle_counter import pulse_seq_pkg::*; #(
  parameter int CW = CW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          zero_o
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt_q;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - ONE;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Pulse-train sequencer: after an accepted start, waits `delay` cycles, then emits
// `count` pulses of `width` high cycles separated by `gap` low cycles.
//
//   state | meaning
//   IDLE  | waiting for start with on=1
//   DELAY | counting down the initial delay
//   HIGH  | signal high, counting pulse width
//   LOW   | signal low, counting inter-pulse gap
//   DONE  | one-cycle completion strobe
module pulse_sequencer import pulse_seq_pkg::*; #(
  parameter int CW = CW_DEF
) (
  input  logic             clock,
  input  logic             reset,
  pulse_sequencer_if.slave bus
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  // Phase length minus one, with zero treated as a length of one.
  function automatic logic [CW-1:0] len_m1(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - ONE;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [CW-1:0] wid_q, wid_d;
  logic [CW-1:0] gap_q, gap_d;
  logic          signal_q, busy_q, done_q, abort_q;
  logic          abort_d;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;

  cycle_counter #(.CW(CW)) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  // Next-state, phase-timer load and remaining-pulse bookkeeping.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    wid_d    = wid_q;
    gap_d    = gap_q;
    abort_d  = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && bus.on) begin
          wid_d = len_m1(bus.width);
          gap_d = len_m1(bus.gap);
          rem_d = bus.count;
          if (bus.count == '0) begin
            state_d = S_DONE;
          end else if (bus.delay == '0) begin
            state_d  = S_HIGH;
            cnt_load = 1'b1;
            cnt_val  = len_m1(bus.width);
          end else begin
            state_d  = S_DELAY;
            cnt_load = 1'b1;
            cnt_val  = bus.delay - ONE;
          end
        end
      end
      S_DELAY, S_LOW: begin
        if (!bus.on) begin
          abort_d = 1'b1;
        end else if (cnt_zero) begin
          state_d  = S_HIGH;
          cnt_load = 1'b1;
          cnt_val  = wid_q;
        end
      end
      S_HIGH: begin
        // Abort is checked first so it wins over completion on the last high cycle.
        if (!bus.on) begin
          abort_d = 1'b1;
        end else if (cnt_zero) begin
          if (rem_q <= ONE) begin
            state_d = S_DONE;
            rem_d   = '0;
          end else begin
            state_d  = S_LOW;
            rem_d    = rem_q - ONE;
            cnt_load = 1'b1;
            cnt_val  = gap_q;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_d) begin
      state_d = S_IDLE;
      rem_d   = '0;
    end
  end

  // State, latched configuration and registered outputs; reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      wid_q    <= '0;
      gap_q    <= '0;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      wid_q    <= wid_d;
      gap_q    <= gap_d;
      signal_q <= (state_d == S_HIGH);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
      abort_q  <= abort_d;
    end
  end

  assign bus.signal = signal_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.abort  = abort_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer: each scenario pushes its expected per-cycle
// {signal,busy,done,abort} trace; a monitor pops and compares on the falling edge.
module tb_pulse_sequencer;

  typedef struct packed {
    int         cyc;
    logic [3:0] v;
    logic [7:0] id;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   t0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pulse_sequencer_if bus ();

  pulse_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clock = ~clock;

  function automatic string name_of(input logic [7:0] id);
    case (id)
      8'd0:    return "reset";
      8'd1:    return "basic";
      8'd2:    return "count0";
      8'd3:    return "zeros";
      8'd4:    return "abort";
      8'd5:    return "abort_last";
      8'd6:    return "done_off";
      8'd7:    return "start_off";
      8'd8:    return "start_busy";
      8'd9:    return "reset_mid";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: compare every expectation scheduled for the current cycle.
  always @(negedge clock) begin
    exp_t       e;
    logic [3:0] got;
    got = {bus.signal, bus.busy, bus.done, bus.abort};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || got !== e.v) begin
        errors++;
        $display("FAIL %s cyc=%0d (sched %0d): got sig/busy/done/abort=%b required=%b",
                 name_of(e.id), cyc, e.cyc, got, e.v);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Character i of each string is the expected value in cycle t+1+i.
  task automatic push_exp(input int t, input logic [7:0] id,
                          input string s, input string b, input string d, input string a);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.cyc = t + 1 + i;
      e.id  = id;
      e.v   = {s[i] == 8'h31, b[i] == 8'h31, d[i] == 8'h31, a[i] == 8'h31};
      sb.push_back(e);
    end
  endtask

  task automatic set_cfg(input logic [7:0] d, input logic [7:0] w,
                         input logic [7:0] g, input logic [7:0] n);
    bus.delay = d;
    bus.width = w;
    bus.gap   = g;
    bus.count = n;
  endtask

  task automatic start_seq(input logic [7:0] d, input logic [7:0] w,
                           input logic [7:0] g, input logic [7:0] n, input logic [7:0] id,
                           input string s, input string b, input string dn, input string a);
    set_cfg(d, w, g, n);
    bus.start = 1'b1;
    t0 = cyc;
    push_exp(t0, id, s, b, dn, a);
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held two cycles while start/on are asserted: nothing may start.
    reset     = 1'b1;
    bus.on    = 1'b1;
    bus.start = 1'b1;
    set_cfg(8'd3, 8'd2, 8'd1, 8'd3);
    push_exp(0, 8'd0, "00000", "00000", "00000", "00000");
    tick();
    tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    wait_until(5);

    // Basic train; next start issued in the first cycle after done.
    start_seq(8'd3, 8'd2, 8'd1, 8'd3, 8'd1,
              "0001101101100", "1111111111110", "0000000000010", "0000000000000");
    wait_until(t0 + 13);
    start_seq(8'd5, 8'd3, 8'd2, 8'd0, 8'd2, "0000", "1000", "1000", "0000");
    wait_until(t0 + 5);

    // Zero delay, width and gap.
    start_seq(8'd0, 8'd0, 8'd0, 8'd2, 8'd3, "10100", "11110", "00010", "00000");
    wait_until(t0 + 6);

    // Abort in the second high phase.
    start_seq(8'd1, 8'd4, 8'd2, 8'd3, 8'd4,
              "011110011000", "111111111000", "000000000000", "000000000100");
    wait_until(t0 + 9);
    bus.on = 1'b0;
    tick();
    bus.on = 1'b1;
    wait_until(t0 + 13);

    // on=0 on the final high cycle: abort wins, no done.
    start_seq(8'd0, 8'd2, 8'd1, 8'd1, 8'd5, "11000", "11000", "00000", "00100");
    wait_until(t0 + 2);
    bus.on = 1'b0;
    tick();
    bus.on = 1'b1;
    wait_until(t0 + 6);

    // on=0 during DONE: completes normally.
    start_seq(8'd0, 8'd1, 8'd1, 8'd1, 8'd6, "1000", "1100", "0100", "0000");
    wait_until(t0 + 2);
    bus.on = 1'b0;
    tick();
    bus.on = 1'b1;
    wait_until(t0 + 5);

    // Start while disarmed is ignored.
    bus.on = 1'b0;
    start_seq(8'd2, 8'd2, 8'd2, 8'd2, 8'd7, "0000", "0000", "0000", "0000");
    bus.on = 1'b1;
    wait_until(t0 + 5);

    // Start and new configuration while busy are ignored.
    start_seq(8'd2, 8'd1, 8'd1, 8'd2, 8'd8,
              "0010100", "1111110", "0000010", "0000000");
    wait_until(t0 + 3);
    set_cfg(8'd0, 8'd5, 8'd0, 8'd4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_until(t0 + 8);

    // Reset in the middle of a high phase.
    start_seq(8'd0, 8'd6, 8'd1, 8'd1, 8'd9,
              "11100000", "11100000", "00000000", "00000000");
    wait_until(t0 + 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_until(t0 + 10);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_sequencer.md
PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 SHALL have parameter CW, default 8, setting the width of all configuration fields and internal counters.
REQ-002 SHALL have port clock, input, 1, single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port on, input, 1, arm/gate; start is accepted only while on=1, and deassertion aborts a sequence.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a sequence.
REQ-006 SHALL have port delay, input, CW, cycles from the accept cycle to the first pulse.
REQ-007 SHALL have port width, input, CW, high cycles per pulse.
REQ-008 SHALL have port gap, input, CW, low cycles between pulses.
REQ-009 SHALL have port count, input, CW, number of pulses.
REQ-010 SHALL have port signal, output, 1, registered pulse-train output.
REQ-011 SHALL have port busy, output, 1, high while a sequence is in progress.
REQ-012 SHALL have port done, output, 1, one-cycle completion strobe.
REQ-013 SHALL have port abort, output, 1, one-cycle strobe when a sequence is cancelled by on=0.

Function
REQ-014 SHALL implement FSM states IDLE, DELAY, HIGH, LOW, DONE.
REQ-015 SHALL accept start only in IDLE with on=1, latching delay, width, gap and count in that cycle t; otherwise start is ignored.
REQ-016 SHALL ignore start and configuration changes while busy=1.
REQ-017 SHALL treat width=0 as 1 and gap=0 as 1.
REQ-018 SHALL skip DELAY when delay=0.
REQ-019 SHALL, when count=0, go directly to DONE: done=1 in cycle t+1, with signal never high.
REQ-020 SHALL drive signal=1 first in cycle t+1+delay, holding it high for width cycles.
REQ-021 SHALL follow each pulse except the last with gap low cycles.
REQ-022 SHALL track remaining pulses with a CW-bit down-counter, without wrap-around.
REQ-023 SHALL assert done for exactly one cycle, the cycle after the last high cycle, then return to IDLE.
REQ-024 SHALL hold busy=1 from cycle t+1 through the done cycle inclusive, and busy=0 in IDLE.
REQ-025 SHALL accept the earliest next start in the cycle after done.
REQ-026 SHALL abort when on=0 is sampled in cycle k while in DELAY, HIGH or LOW; in cycle k+1: signal=0, busy=0, abort=1, state IDLE, and done is not asserted.
REQ-027 SHALL give abort priority over completion when on=0 coincides with the last high cycle.
REQ-028 SHALL let the DONE state complete normally if on=0 is sampled during DONE.
REQ-029 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.

Reset
REQ-030 SHALL, with reset=1 at a rising edge, enter IDLE and clear signal, busy, done, abort and all counters in the next cycle, regardless of other inputs.
REQ-031 SHALL give reset priority over start, abort and completion.
REQ-032 SHALL, on reset mid-sequence, assert neither done nor abort.

Structure
REQ-033 SHALL take the state enumeration (IDLE, DELAY, HIGH, LOW, DONE) and the default CW constant from shared package pulse_seq_pkg.
REQ-034 SHALL instantiate one sub-module, cycle_counter: a loadable CW-bit down-counter with a zero flag, reused for the DELAY, HIGH and LOW phases.
REQ-035 SHALL keep the pulse-remaining counter in the top level.

Verification
REQ-036 SHALL cover reset: reset=1 for 2 cycles with start=1, on=1 -> signal=busy=done=abort=0, and no sequence starts.
REQ-037 SHALL cover a basic train: delay=3, width=2, gap=1, count=3, start at cycle t -> signal high in t+4..t+5, t+7..t+8, t+10..t+11; done=1 at t+12 only; busy=1 in t+1..t+12.
REQ-038 SHALL cover zero handling: delay=0, width=0, gap=0, count=2 -> signal high at t+1 and t+3, low at t+2; done at t+4.
REQ-039 SHALL cover count=0: any delay and width -> done=1 at t+1, busy=1 only at t+1, signal never high.
REQ-040 SHALL cover abort: delay=1, width=4, gap=2, count=3, on=0 sampled in the second high phase -> next cycle signal=0, abort=1, busy=0; done never asserted.
REQ-041 SHALL cover ignored requests: start with on=0 -> no response; start while busy -> train unchanged; reset asserted mid-HIGH -> all outputs 0 in the following cycle.
